bcd_adder: RTL and testbench
============================

Name: bcd_adder

Overview:
- Registered, parameterisable packed-BCD adder: adds two DIGITS-digit BCD operands plus a carry-in, producing a BCD sum and a decimal carry-out.
- Digits ripple combinationally, least-significant digit first. The result is captured in output registers one clock after a valid input.
- Used as the decimal arithmetic primitive in datapaths that keep values in BCD. DIGITS=1 gives the basic single-digit adder.

Parameters:
- DIGITS, 1, number of BCD digits per operand (legal range 1..8).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; a result is captured only when high.
- a  input  4*DIGITS  augend, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  addend, packed BCD, same packing as a.
- cin  input  1  decimal carry into digit 0.
- sum  output  4*DIGITS  registered BCD sum, same packing as a.
- cout  output  1  registered decimal carry out of the top digit.
- out_valid  output  1  registered; high for exactly one cycle per accepted input.
- err  output  1  registered; high when any digit of a or b was greater than 9 in the accepted input.

Behaviour:
- Reset (rst_n low, asynchronous): sum=0, cout=0, out_valid=0, err=0.
- Reset release is synchronous to clk. Asserting reset mid-operation discards any pending result.
- Per-digit rule for digit i, with c0=cin:
  - raw_i = a_i + b_i + c_i, computed 5 bits wide (range 0..31).
  - If raw_i > 9: s_i = (raw_i + 6) mod 16 and c_(i+1) = 1.
  - Otherwise: s_i = raw_i and c_(i+1) = 0.
  - cout = c_DIGITS.
- Non-BCD input digits (>9) are still processed by the same rule, so the result is deterministic. err is set for that result. sum and cout are then not guaranteed to be decimal-correct.
- Latency is 1 cycle. On a clk edge with in_valid=1: sum, cout and err load the combinational result, and out_valid goes to 1.
- On a clk edge with in_valid=0: out_valid goes to 0, and sum, cout and err hold their previous values.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- cin participates only when in_valid=1.
- Maximum legal result: all digits 9 with cin=1 gives sum all 9s and cout=1.
- There are no internal state machines beyond the output registers.

Decomposition:
- Package bcd_pkg:
  - constants BCD_MAX=9 and BCD_CORR=6;
  - typedef bcd_digit_t (4-bit);
  - function is_bcd(digit) returning 1 when digit <= 9.
- Sub-module bcd_digit_add: purely combinational single-digit adder.
  - Inputs a, b (4 bits each) and ci (1 bit); outputs s (4 bits), co and bad (bad = either input >9).
  - The top level instantiates DIGITS copies via generate, chains co to ci, ORs the bad flags into err, and registers the outputs.

Test Plan:
- Reset: hold rst_n low with random inputs and in_valid=1 -> sum=0, cout=0, out_valid=0, err=0 throughout. Release reset, then a=1, b=1, cin=0, in_valid=1 -> next cycle sum=2, cout=0, out_valid=1.
- DIGITS=1 no-correction cases: 2+1+0 -> sum=3, cout=0. 5+4+0 -> sum=9, cout=0, err=0.
- DIGITS=1 correction cases: 7+5+0 -> sum=2, cout=1. 9+9+1 -> sum=9, cout=1. 0+9+1 -> sum=0, cout=1.
- Multi-digit ripple, DIGITS=4: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. a=0x1234, b=0x5678, cin=1 -> sum=0x6913, cout=0.
- Invalid input, DIGITS=1: a=0xA, b=0x0, cin=0 -> err=1, sum=0x0, cout=1. The next valid input 3+4 -> err=0, sum=7.
- Handshake: three back-to-back valid inputs, then in_valid=0 for two cycles -> out_valid=1,1,1,0,0, and sum/cout hold the third result. Asynchronous reset pulse mid-stream -> outputs go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants, digit type and a validity helper for the packed-BCD adder.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic is_bcd(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit decimal adder; non-BCD inputs follow the same
// correction rule and are flagged on bad.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co,
  output logic       bad
);

  logic [4:0] raw;
  logic [4:0] corrected;

  always_comb begin
    raw       = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    corrected = raw + {1'b0, BCD_CORR};
    s         = raw[3:0];
    co        = 1'b0;
    // Values up to 31 are possible with non-BCD digits; the low nibble of raw+6 still applies.
    if (raw > {1'b0, BCD_MAX}) begin
      s  = corrected[3:0];
      co = 1'b1;
    end
    bad = ~is_bcd(a) | ~is_bcd(b);
  end

endmodule

// File: rtl/bcd_adder.sv
// Registered DIGITS-wide packed-BCD adder: digits ripple combinationally and
// the result is captured one clock after in_valid.
module bcd_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  out_valid,
  output logic                  err
);

  logic [DIGITS:0]       carry;
  logic [DIGITS-1:0]     bad;
  logic [4*DIGITS-1:0]   sum_comb;

  assign carry[0] = cin;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_add u_digit (
      .a   (a[4*i +: 4]),
      .b   (b[4*i +: 4]),
      .ci  (carry[i]),
      .s   (sum_comb[4*i +: 4]),
      .co  (carry[i+1]),
      .bad (bad[i])
    );
  end

  logic [4*DIGITS-1:0] sum_d, sum_q;
  logic                cout_d, cout_q;
  logic                out_valid_d, out_valid_q;
  logic                err_d, err_q;

  // Result registers hold between accepted inputs; only out_valid drops.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    err_d       = err_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum_comb;
      cout_d = carry[DIGITS];
      err_d  = |bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_adder.sv
// Directed testbench for bcd_adder with a single-digit and a four-digit instance.
module tb_bcd_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v1 = 1'b0, cin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic [3:0]  sum1;
  logic        cout1, ov1, err1;

  logic        v4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic [15:0] sum4;
  logic        cout4, ov4, err4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_adder #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .out_valid(ov1), .err(err1)
  );

  bcd_adder #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .out_valid(ov4), .err(err4)
  );

  // Drive on the falling edge, then settle just after the next rising edge.
  task automatic cyc1(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; v1 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; v4 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom); v1 = 1'b1;
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom); v4 = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({sum1, cout1, ov1, err1} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_d1 cycle %0d: got sum=%h cout=%b ov=%b err=%b, want all 0", i, sum1, cout1, ov1, err1);
      end
      n_checks++;
      if ({sum4, cout4, ov4, err4} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_d4 cycle %0d: got sum=%h cout=%b ov=%b err=%b, want all 0", i, sum4, cout4, ov4, err4);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; v1 = 1'b0; v4 = 1'b0;
    cyc1(4'd1, 4'd1, 1'b0, 1'b1);
    n_checks++;
    if ({sum1, cout1, ov1} !== {4'd2, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_add: got sum=%h cout=%b ov=%b, want sum=2 cout=0 ov=1", sum1, cout1, ov1);
    end
  endtask

  task automatic test_single_digit();
    logic [3:0] ta[5], tb[5], es[5];
    logic       tc[5], ec[5];
    ta = '{4'd2, 4'd5, 4'd7, 4'd9, 4'd0};
    tb = '{4'd1, 4'd4, 4'd5, 4'd9, 4'd9};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd0};
    ec = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      cyc1(ta[i], tb[i], tc[i], 1'b1);
      n_checks++;
      if ({sum1, cout1, err1, ov1} !== {es[i], ec[i], 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL single_digit %0d+%0d+%0d: got sum=%h cout=%b err=%b ov=%b, want sum=%h cout=%b err=0 ov=1",
                 ta[i], tb[i], tc[i], sum1, cout1, err1, ov1, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_multi_digit();
    cyc4(16'h9999, 16'h0001, 1'b0, 1'b1);
    n_checks++;
    if ({sum4, cout4, err4, ov4} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ripple_9999_plus_1: got sum=%h cout=%b err=%b ov=%b, want sum=0000 cout=1 err=0 ov=1", sum4, cout4, err4, ov4);
    end
    cyc4(16'h1234, 16'h5678, 1'b1, 1'b1);
    n_checks++;
    if ({sum4, cout4, err4} !== {16'h6913, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ripple_1234_5678_c1: got sum=%h cout=%b err=%b, want sum=6913 cout=0 err=0", sum4, cout4, err4);
    end
    cyc4(16'h9999, 16'h9999, 1'b1, 1'b1);
    n_checks++;
    if ({sum4, cout4} !== {16'h9999, 1'b1}) begin
      n_fail++;
      $display("FAIL ripple_max: got sum=%h cout=%b, want sum=9999 cout=1", sum4, cout4);
    end
    cyc4(16'h00A0, 16'h0000, 1'b0, 1'b1);
    n_checks++;
    if ({sum4, cout4, err4} !== {16'h0100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ripple_bad_digit1: got sum=%h cout=%b err=%b, want sum=0100 cout=0 err=1", sum4, cout4, err4);
    end
    cyc4(16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_invalid_digit();
    cyc1(4'hA, 4'h0, 1'b0, 1'b1);
    n_checks++;
    if ({err1, sum1, cout1} !== {1'b1, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL invalid_A_plus_0: got err=%b sum=%h cout=%b, want err=1 sum=0 cout=1", err1, sum1, cout1);
    end
    cyc1(4'd3, 4'd4, 1'b0, 1'b1);
    n_checks++;
    if ({err1, sum1, cout1} !== {1'b0, 4'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL invalid_recover: got err=%b sum=%h cout=%b, want err=0 sum=7 cout=0", err1, sum1, cout1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ov_seen;
    cyc1(4'd1, 4'd2, 1'b0, 1'b1);
    ov_seen[0] = ov1;
    cyc1(4'd3, 4'd3, 1'b0, 1'b1);
    ov_seen[1] = ov1;
    n_checks++;
    if (sum1 !== 4'd6) begin
      n_fail++;
      $display("FAIL b2b_second_sum: got %h, want 6", sum1);
    end
    cyc1(4'd9, 4'd9, 1'b0, 1'b1);
    ov_seen[2] = ov1;
    n_checks++;
    if (ov_seen !== 3'b111) begin
      n_fail++;
      $display("FAIL b2b_out_valid: got %b, want 111", ov_seen);
    end
    for (int i = 0; i < 2; i++) begin
      cyc1(4'd2, 4'd2, 1'b1, 1'b0);
      n_checks++;
      if ({ov1, sum1, cout1} !== {1'b0, 4'd8, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_idle_hold %0d: got ov=%b sum=%h cout=%b, want ov=0 sum=8 cout=1", i, ov1, sum1, cout1);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc1(4'd5, 4'd4, 1'b0, 1'b1);
    @(negedge clk);
    a1 = 4'd7; b1 = 4'd5; cin1 = 1'b0; v1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sum1, cout1, ov1, err1} !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got sum=%h cout=%b ov=%b err=%b, want all 0", sum1, cout1, ov1, err1);
    end
    @(negedge clk);
    rst_n = 1'b1; v1 = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({sum1, cout1, ov1} !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset_discard: got sum=%h cout=%b ov=%b, want all 0", sum1, cout1, ov1);
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_multi_digit();
    test_invalid_digit();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
